dmi_arbiter: RTL

DMI_ARBITER -- requirements
Module: dmi_arbiter

---
 rtl/dmi_arbiter_pkg.sv | 33 +++
 rtl/dmi_arbiter_rr_grant.sv | 39 +++
 rtl/dmi_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dmi_arbiter_pkg.sv
// Shared DMI types and arbiter constants.
// Requests carry a 7-bit address, a DTM opcode and 32 bits of data.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } dmi_arb_state_e;

endpackage

// File: rtl/dmi_arbiter_rr_grant.sv
// Round-robin grant: first valid index at or above ptr_i, wrapping to 0.
// Purely combinational; the caller owns the pointer register.
module rr_grant #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    logic [NumReq-1:0] upper;
    logic [NumReq-1:0] pick;
    logic              found;

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_upper
        assign upper[gi] = valid_i[gi] && (IdxW'(gi) >= ptr_i);
    end

    // Prefer requesters above the pointer; otherwise wrap to the lowest.
    assign pick  = (|upper) ? upper : valid_i;
    assign any_o = |valid_i;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            if (!found && pick[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IdxW'(k);
            end
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// Multiplexes several DMI requesters onto one Debug Module port,
// one transaction in flight, with requester abort and optional response timeout.
module dmi_arbiter
    import dm::*;
#(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned ObsTimeout = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  dmi_req_t [NumReq-1:0] req_i,
    input  logic [NumReq-1:0]     req_valid_i,
    output logic [NumReq-1:0]     req_ready_o,
    input  logic [NumReq-1:0]     clear_i,
    output dmi_resp_t             resp_o,
    output logic [NumReq-1:0]     resp_valid_o,
    input  logic [NumReq-1:0]     resp_ready_i,
    output dmi_req_t              dm_req_o,
    output logic                  dm_req_valid_o,
    input  logic                  dm_req_ready_i,
    input  dmi_resp_t             dm_resp_i,
    input  logic                  dm_resp_valid_i,
    output logic                  dm_resp_ready_o,
    output logic                  busy_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = (ObsTimeout > 0) ? $clog2(ObsTimeout + 1) : 1;

    dmi_arb_state_e  state_q, state_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] owner_q, owner_d;
    dmi_req_t        dm_req_q, dm_req_d;
    dmi_resp_t       resp_q, resp_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timed_out_q, timed_out_d;
    logic            dm_req_valid_q;
    logic            dm_resp_ready_q;

    logic [NumReq-1:0] gnt_oh;
    logic [IdxW-1:0]   gnt_idx;
    logic              gnt_any;
    logic              owner_clear;
    logic              owner_resp_ready;
    logic              timeout_hit;

    // A requester raising clear is never granted in that cycle.
    rr_grant #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_grant (
        .valid_i (req_valid_i & ~clear_i),
        .ptr_i   (rr_q),
        .gnt_o   (gnt_oh),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    assign owner_clear      = clear_i[owner_q];
    assign owner_resp_ready = resp_ready_i[owner_q];

    if (ObsTimeout > 0) begin : g_timeout
        assign timeout_hit = (cnt_q == CntW'(ObsTimeout - 1));
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            rr_q            <= '0;
            owner_q         <= '0;
            dm_req_q        <= '0;
            resp_q          <= '0;
            cnt_q           <= '0;
            timed_out_q     <= 1'b0;
            dm_req_valid_q  <= 1'b0;
            dm_resp_ready_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_q            <= rr_d;
            owner_q         <= owner_d;
            dm_req_q        <= dm_req_d;
            resp_q          <= resp_d;
            cnt_q           <= cnt_d;
            timed_out_q     <= timed_out_d;
            dm_req_valid_q  <= (state_d == ISSUE);
            dm_resp_ready_q <= (state_d == WAIT) || (state_d == DRAIN);
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        dm_req_d    = dm_req_q;
        resp_d      = resp_q;
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d     = ISSUE;
                    dm_req_d    = req_i[gnt_idx];
                    owner_d     = gnt_idx;
                    rr_d        = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
                    timed_out_d = 1'b0;
                end
            end
            ISSUE: begin
                if (owner_clear) begin
                    state_d = dm_req_ready_i ? DRAIN : IDLE;
                end else if (dm_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (owner_clear) begin
                    // A response arriving with the clear is consumed right here.
                    state_d = dm_resp_valid_i ? IDLE : DRAIN;
                end else if (dm_resp_valid_i) begin
                    state_d = RESP;
                    resp_d  = dm_resp_i;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    resp_d      = '{data: 32'h0, resp: DTM_BUSY};
                    timed_out_d = 1'b1;
                end
            end
            RESP: begin
                // After a timeout the DM still owes a response; swallow it.
                if (owner_clear || owner_resp_ready) begin
                    state_d = timed_out_q ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (dm_resp_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ObsTimeout > 0) begin
            if (state_d == WAIT && state_q != WAIT) begin
                cnt_d = '0;
            end else if (state_q == WAIT && cnt_q != CntW'(ObsTimeout)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        if (rst_ni && state_q == IDLE) begin
            req_ready_o = gnt_oh;
        end
        if (rst_ni && state_q == RESP) begin
            resp_valid_o[owner_q] = 1'b1;
        end
    end

    assign busy_o          = rst_ni && (state_q != IDLE);
    assign dm_req_valid_o  = dm_req_valid_q;
    assign dm_resp_ready_o = dm_resp_ready_q;
    assign dm_req_o        = dm_req_q;
    assign resp_o          = resp_q;

endmodule
